hand_controller: RTL and testbench
==================================

# hand_controller

Heads-up Texas Hold'em hand sequencer: the producer side of the game-state bus that `top_screen` renders. It replaces the hard-wired test vectors in the top level. It takes debounced button pulses, fetches cards from a deck block over a req/ack handshake, and runs blinds, betting rounds, streets, showdown via an external evaluator, and payout. All outputs are registered and drive `top_screen` directly.

## Interface
- `START_STACK`, default 1000: stack per player loaded on game start.
- `SMALL_BLIND`, default 10: small blind, posted by the dealer.
- `BIG_BLIND`, default 20: big blind and floor of the minimum raise.
- `clk` in 1: the one clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `btn_start`, `act_check_call`, `act_bet_raise`, `act_fold` in 1 each: 1-cycle pulses, already synchronized and debounced.
- `bet_amount` in 11: requested raise increment, taken from the switches.
- `card_req` out 1, `card_ack` in 1, `card_in` in card_t: deck handshake.
- `eval_start` out 1, `eval_done` in 1, `eval_winner` in 1, `eval_tie` in 1: showdown evaluator interface.
- `player_cards[2][2]`, `flop_card[3]`, `turn_card`, `river_card` out card_t: dealt cards.
- `player_stacks[2]`, `player_pots[2]`, `pot_size`, `min_bet_or_raise`, `call_size` out 11 each: chip counts.
- `current_player`, `current_dealer`, `winner`, `if_BetCheck` out 1 each: turn, button, result and action-label flags.
- `curr_state` out hand_state_t: one of preflop/flop/turn/river/showdown.
- `start_state`, `game_state`, `wait_state` out 1 each: screen select, one-hot.

## Operation
- **FSM states**: IDLE, BLINDS, DEAL, BET, CLOSE, EVAL, WAIT.
- **Screen select**: `start_state`=IDLE. `wait_state`=WAIT. `game_state`=all other states.
- **IDLE**: `btn_start` loads both stacks with START_STACK and goes to BLINDS.
- **BLINDS**: dealer posts SMALL_BLIND and the other player posts BIG_BLIND; each post is clamped to that player's stack. `curr_state`=preflop. Go to DEAL.
- **DEAL**:
  - Preflop deals 4 cards in this order: [0][0], [1][0], [0][1], [1][1].
  - Flop deals 3 cards, turn 1, river 1.
  - When either stack is 0, streets are run out without betting and the FSM goes to EVAL after the river.
  - Otherwise go to BET.
- **BET, first to act**: the dealer preflop; the non-dealer postflop.
- **Derived values**:
  - `call_size` = min(opponent pot − own pot, own stack).
  - `if_BetCheck` = (opponent pot == own pot).
- **Actions** (only `current_player` may act):
  - Priority when pulses coincide: fold > bet_raise > check_call.
  - *check_call*: moves `call_size` from stack to pot.
  - *bet_raise*: inc = max(`bet_amount`, `min_bet_or_raise`); moves min(`call_size`+inc, stack) from stack to pot. If inc ≥ `min_bet_or_raise`, then `min_bet_or_raise` ← inc. Clears the opponent's acted flag.
  - *fold*: opponent wins; all pots and `pot_size` go to the opponent; go to WAIT.
  - Every action sets the actor's acted flag and toggles `current_player`.
  - A pulse arriving in any other state is ignored.
- **Street close**: when both acted flags are set and the pots are equal, or either stack is 0 and the non-all-in player has acted, go to CLOSE.
- **CLOSE**:
  - Any uncalled excess is returned to the bettor's stack.
  - `pot_size` += both pots; both pots are cleared.
  - Acted flags are cleared and `min_bet_or_raise` ← BIG_BLIND.
  - `curr_state` advances one street, then DEAL. After the river the FSM goes to EVAL with `curr_state`=showdown.
- **EVAL**:
  - Pulse `eval_start`, then wait for `eval_done`.
  - Winner: takes all of `pot_size`; `winner` ← `eval_winner`.
  - Tie: each player gets `pot_size`/2; the odd chip goes to the non-dealer.
  - Go to WAIT.
- **WAIT**: `btn_start` does the following:
  - If either stack is 0, go to IDLE.
  - Otherwise toggle `current_dealer`, clear all pots, and go to BLINDS.
- **Widths**: all chip arithmetic is 11-bit unsigned. The total in play is ≤ 2·START_STACK, so the parameter is restricted to ≤ 1023.

## Timing
- **Reset values**:
  - stacks = START_STACK; pots, `pot_size`, `call_size` = 0; `min_bet_or_raise` = BIG_BLIND.
  - `current_player`, `current_dealer`, `winner` = 0; `if_BetCheck` = 1.
  - All cards = 0; `curr_state` = preflop.
  - `start_state` = 1, other screen selects 0; `card_req` = 0, `eval_start` = 0.
- **Reset mid-operation**: takes effect on the next edge and drops `card_req`/`eval_start` immediately.
- **Action latency**: an action pulse at edge N updates stack, pot and `current_player` at N+1. `call_size`/`if_BetCheck` are valid at N+2.
- **Close latency**: close is detected and CLOSE is entered at N+2. CLOSE itself takes 1 cycle.
- **Card handshake**:
  - `card_req` is held high in DEAL until the last card of the street is taken.
  - `card_in` is captured on every edge where `card_req` & `card_ack`; back-to-back acks are legal.
  - `card_ack` while `card_req`=0 is ignored.
- **Evaluator handshake**:
  - `eval_start` is high for exactly 1 cycle.
  - `eval_done` is sampled from the cycle after `eval_start`; `eval_winner`/`eval_tie` are sampled in the same cycle as `eval_done`.

## Test plan
1. **Fresh hand**: reset, `btn_start`, 4 acks → p0 stack 990 pot 10, p1 stack 980 pot 20, `current_player`=0, `call_size`=10, `if_BetCheck`=0.
2. **Preflop to flop**: p0 check_call, then p1 check_call → `pot_size`=40, pots 0, 3 card_req/ack cycles, `curr_state`=flop, `current_player`=1, `if_BetCheck`=1.
3. **Minimum raise enforced**: preflop, `bet_amount`=5, p0 bet_raise → p0 pot 40, stack 960; `min_bet_or_raise`=20; p1 `call_size`=20.
4. **Simultaneous pulses**: fold and check_call in the same cycle preflop → fold wins; p1 stack 1010, `winner`=1, `wait_state`=1.
5. **All-in tie**: all-in called preflop → flop/turn/river dealt with no BET, `eval_start` pulse; `eval_tie`=1 with `pot_size`=2000 → both stacks 1000.
6. **Reset in DEAL**: assert `reset` mid-DEAL with `card_req`=1 → next cycle `card_req`=0, `start_state`=1, all outputs at their reset values.

Source files
------------

// File: rtl/hand_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hand_controller
//  Description : Heads-up Texas Hold'em hand sequencer driving the game-state
//                bus (blinds, dealing, betting, showdown, payout).
//  Revision    : 1.0 - initial release
// ============================================================================

package hand_controller_pkg;
    typedef logic [5:0] card_t;
    typedef enum logic [2:0] {
        HS_PREFLOP  = 3'd0,
        HS_FLOP     = 3'd1,
        HS_TURN     = 3'd2,
        HS_RIVER    = 3'd3,
        HS_SHOWDOWN = 3'd4
    } hand_state_t;
endpackage

module hand_controller
    import hand_controller_pkg::*;
#(
    parameter int START_STACK = 1000,
    parameter int SMALL_BLIND = 10,
    parameter int BIG_BLIND   = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        act_check_call,
    input  logic        act_bet_raise,
    input  logic        act_fold,
    input  logic [10:0] bet_amount,
    output logic        card_req,
    input  logic        card_ack,
    input  card_t       card_in,
    output logic        eval_start,
    input  logic        eval_done,
    input  logic        eval_winner,
    input  logic        eval_tie,
    output card_t       player_cards [2][2],
    output card_t       flop_card [3],
    output card_t       turn_card,
    output card_t       river_card,
    output logic [10:0] player_stacks [2],
    output logic [10:0] player_pots [2],
    output logic [10:0] pot_size,
    output logic [10:0] min_bet_or_raise,
    output logic [10:0] call_size,
    output logic        current_player,
    output logic        current_dealer,
    output logic        winner,
    output logic        if_BetCheck,
    output hand_state_t curr_state,
    output logic        start_state,
    output logic        game_state,
    output logic        wait_state
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_blinds = 3'd1;
    localparam logic [2:0] c_st_deal   = 3'd2;
    localparam logic [2:0] c_st_bet    = 3'd3;
    localparam logic [2:0] c_st_close  = 3'd4;
    localparam logic [2:0] c_st_eval   = 3'd5;
    localparam logic [2:0] c_st_wait   = 3'd6;

    localparam logic [10:0] c_start = 11'(START_STACK);
    localparam logic [10:0] c_sb    = 11'(SMALL_BLIND);
    localparam logic [10:0] c_bb    = 11'(BIG_BLIND);

    logic [2:0]  r_state, w_state_next;
    logic [1:0]  r_acted;
    logic [1:0]  r_card_cnt;
    logic        w_p, w_o, w_dlr, w_ndl;
    logic [10:0] w_own_pot, w_opp_pot, w_own_stack, w_gap;
    logic [10:0] w_call, w_inc, w_raise_amt, w_sb_post, w_bb_post, w_half;
    logic [11:0] w_raise_sum;
    logic [1:0]  w_street_last;
    logic        w_any_broke, w_close, w_take_card, w_last_card;

    always_comb begin
        w_p         = current_player;
        w_o         = ~current_player;
        w_dlr       = current_dealer;
        w_ndl       = ~current_dealer;
        w_own_pot   = player_pots[w_p];
        w_opp_pot   = player_pots[w_o];
        w_own_stack = player_stacks[w_p];
        w_gap       = w_opp_pot - w_own_pot;
        w_call      = '0;
        if (w_opp_pot > w_own_pot)
            w_call = (w_gap < w_own_stack) ? w_gap : w_own_stack;
        w_inc       = (bet_amount > min_bet_or_raise) ? bet_amount : min_bet_or_raise;
        // 12-bit sum: a large switch value plus a call can exceed 11 bits
        w_raise_sum = {1'b0, w_call} + {1'b0, w_inc};
        w_raise_amt = (w_raise_sum > {1'b0, w_own_stack}) ? w_own_stack : w_raise_sum[10:0];
        w_sb_post   = (player_stacks[w_dlr] < c_sb) ? player_stacks[w_dlr] : c_sb;
        w_bb_post   = (player_stacks[w_ndl] < c_bb) ? player_stacks[w_ndl] : c_bb;
        w_any_broke = (player_stacks[0] == '0) || (player_stacks[1] == '0);
        w_close     = ((r_acted == 2'b11) && (player_pots[0] == player_pots[1]))
                   || ((player_stacks[0] == '0) && (r_acted[1] || (player_stacks[1] == '0)))
                   || ((player_stacks[1] == '0) && r_acted[0]);
        case (curr_state)
            HS_PREFLOP: w_street_last = 2'd3;
            HS_FLOP:    w_street_last = 2'd2;
            default:    w_street_last = 2'd0;
        endcase
        w_take_card = card_req & card_ack;
        w_last_card = w_take_card && (r_card_cnt == w_street_last);
        w_half      = {1'b0, pot_size[10:1]};
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:   if (btn_start) w_state_next = c_st_blinds;
            c_st_blinds: w_state_next = c_st_deal;
            c_st_deal:   if (w_last_card) w_state_next = w_any_broke ? c_st_close : c_st_bet;
            c_st_bet: begin
                if (w_close)       w_state_next = c_st_close;
                else if (act_fold) w_state_next = c_st_wait;
            end
            c_st_close:  w_state_next = (curr_state == HS_RIVER) ? c_st_eval : c_st_deal;
            c_st_eval:   if (!eval_start && eval_done) w_state_next = c_st_wait;
            c_st_wait:   if (btn_start) w_state_next = w_any_broke ? c_st_idle : c_st_blinds;
            default:     w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acted            <= '0;
            r_card_cnt         <= '0;
            card_req           <= 1'b0;
            eval_start         <= 1'b0;
            player_cards[0][0] <= '0;
            player_cards[0][1] <= '0;
            player_cards[1][0] <= '0;
            player_cards[1][1] <= '0;
            flop_card[0]       <= '0;
            flop_card[1]       <= '0;
            flop_card[2]       <= '0;
            turn_card          <= '0;
            river_card         <= '0;
            player_stacks[0]   <= c_start;
            player_stacks[1]   <= c_start;
            player_pots[0]     <= '0;
            player_pots[1]     <= '0;
            pot_size           <= '0;
            min_bet_or_raise   <= c_bb;
            call_size          <= '0;
            current_player     <= 1'b0;
            current_dealer     <= 1'b0;
            winner             <= 1'b0;
            if_BetCheck        <= 1'b1;
            curr_state         <= HS_PREFLOP;
            start_state        <= 1'b1;
            game_state         <= 1'b0;
            wait_state         <= 1'b0;
        end else begin
            eval_start  <= 1'b0;
            call_size   <= w_call;
            if_BetCheck <= (w_opp_pot == w_own_pot);
            start_state <= (w_state_next == c_st_idle);
            wait_state  <= (w_state_next == c_st_wait);
            game_state  <= (w_state_next != c_st_idle) && (w_state_next != c_st_wait);

            case (r_state)
                c_st_idle: begin
                    if (btn_start) begin
                        player_stacks[0] <= c_start;
                        player_stacks[1] <= c_start;
                    end
                end
                c_st_blinds: begin
                    player_pots[w_dlr]   <= w_sb_post;
                    player_stacks[w_dlr] <= player_stacks[w_dlr] - w_sb_post;
                    player_pots[w_ndl]   <= w_bb_post;
                    player_stacks[w_ndl] <= player_stacks[w_ndl] - w_bb_post;
                    pot_size             <= '0;
                    r_acted              <= '0;
                    min_bet_or_raise     <= c_bb;
                    curr_state           <= HS_PREFLOP;
                    card_req             <= 1'b1;
                    r_card_cnt           <= '0;
                end
                c_st_deal: begin
                    if (w_take_card) begin
                        case (curr_state)
                            HS_PREFLOP: player_cards[r_card_cnt[0]][r_card_cnt[1]] <= card_in;
                            HS_FLOP: begin
                                case (r_card_cnt)
                                    2'd0:    flop_card[0] <= card_in;
                                    2'd1:    flop_card[1] <= card_in;
                                    default: flop_card[2] <= card_in;
                                endcase
                            end
                            HS_TURN: turn_card  <= card_in;
                            default: river_card <= card_in;
                        endcase
                        r_card_cnt <= r_card_cnt + 2'd1;
                        if (w_last_card) begin
                            card_req       <= 1'b0;
                            current_player <= (curr_state == HS_PREFLOP) ? w_dlr : w_ndl;
                        end
                    end
                end
                c_st_bet: begin
                    if (!w_close && (act_fold || act_bet_raise || act_check_call)) begin
                        r_acted[w_p]   <= 1'b1;
                        current_player <= w_o;
                        if (act_fold) begin
                            player_stacks[w_o] <= player_stacks[w_o] + player_pots[0]
                                                + player_pots[1] + pot_size;
                            player_pots[0]     <= '0;
                            player_pots[1]     <= '0;
                            pot_size           <= '0;
                            winner             <= w_o;
                        end else if (act_bet_raise) begin
                            player_stacks[w_p] <= w_own_stack - w_raise_amt;
                            player_pots[w_p]   <= w_own_pot + w_raise_amt;
                            min_bet_or_raise   <= w_inc;
                            r_acted[w_o]       <= 1'b0;
                        end else begin
                            player_stacks[w_p] <= w_own_stack - w_call;
                            player_pots[w_p]   <= w_own_pot + w_call;
                        end
                    end
                end
                c_st_close: begin
                    // only the matched part of the pots is committed; the rest goes back
                    if (player_pots[0] >= player_pots[1]) begin
                        player_stacks[0] <= player_stacks[0] + (player_pots[0] - player_pots[1]);
                        pot_size         <= pot_size + player_pots[1] + player_pots[1];
                    end else begin
                        player_stacks[1] <= player_stacks[1] + (player_pots[1] - player_pots[0]);
                        pot_size         <= pot_size + player_pots[0] + player_pots[0];
                    end
                    player_pots[0]   <= '0;
                    player_pots[1]   <= '0;
                    r_acted          <= '0;
                    min_bet_or_raise <= c_bb;
                    case (curr_state)
                        HS_PREFLOP: curr_state <= HS_FLOP;
                        HS_FLOP:    curr_state <= HS_TURN;
                        HS_TURN:    curr_state <= HS_RIVER;
                        default:    curr_state <= HS_SHOWDOWN;
                    endcase
                    if (curr_state == HS_RIVER) begin
                        eval_start <= 1'b1;
                    end else begin
                        card_req   <= 1'b1;
                        r_card_cnt <= '0;
                    end
                end
                c_st_eval: begin
                    if (!eval_start && eval_done) begin
                        if (eval_tie) begin
                            player_stacks[w_ndl] <= player_stacks[w_ndl] + w_half
                                                  + {10'd0, pot_size[0]};
                            player_stacks[w_dlr] <= player_stacks[w_dlr] + w_half;
                        end else begin
                            player_stacks[eval_winner] <= player_stacks[eval_winner] + pot_size;
                            winner                     <= eval_winner;
                        end
                        pot_size <= '0;
                    end
                end
                c_st_wait: begin
                    if (btn_start && !w_any_broke) begin
                        current_dealer <= w_ndl;
                        player_pots[0] <= '0;
                        player_pots[1] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hand_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hand_controller
//  Description : Directed, table-driven self-checking bench for hand_controller.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_hand_controller;
    import hand_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset, btn_start, act_check_call, act_bet_raise, act_fold;
    logic [10:0] bet_amount;
    logic        card_req, card_ack;
    card_t       card_in;
    logic        eval_start, eval_done, eval_winner, eval_tie;
    card_t       player_cards [2][2];
    card_t       flop_card [3];
    card_t       turn_card, river_card;
    logic [10:0] player_stacks [2];
    logic [10:0] player_pots [2];
    logic [10:0] pot_size, min_bet_or_raise, call_size;
    logic        current_player, current_dealer, winner, if_BetCheck;
    hand_state_t curr_state;
    logic        start_state, game_state, wait_state;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hand_controller dut (
        .clk(clk), .reset(reset), .btn_start(btn_start),
        .act_check_call(act_check_call), .act_bet_raise(act_bet_raise), .act_fold(act_fold),
        .bet_amount(bet_amount), .card_req(card_req), .card_ack(card_ack), .card_in(card_in),
        .eval_start(eval_start), .eval_done(eval_done), .eval_winner(eval_winner), .eval_tie(eval_tie),
        .player_cards(player_cards), .flop_card(flop_card), .turn_card(turn_card), .river_card(river_card),
        .player_stacks(player_stacks), .player_pots(player_pots), .pot_size(pot_size),
        .min_bet_or_raise(min_bet_or_raise), .call_size(call_size),
        .current_player(current_player), .current_dealer(current_dealer), .winner(winner),
        .if_BetCheck(if_BetCheck), .curr_state(curr_state),
        .start_state(start_state), .game_state(game_state), .wait_state(wait_state)
    );

    typedef struct {
        logic        cc, br, fd;
        logic [10:0] amt;
        logic [10:0] s0, s1, p0, p1, call, minr;
        logic        cp, ifbc;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
    endtask

    task automatic act(input logic cc, input logic br, input logic fd, input logic [10:0] amt);
        bet_amount     = amt;
        act_check_call = cc;
        act_bet_raise  = br;
        act_fold       = fd;
        @(negedge clk);
        act_check_call = 1'b0;
        act_bet_raise  = 1'b0;
        act_fold       = 1'b0;
    endtask

    task automatic deal(input int n, input logic [5:0] base);
        int t = 0;
        while (card_req !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("card_req raised", card_req, 1);
        if (card_req === 1'b1) begin
            for (int i = 0; i < n; i++) begin
                card_in  = base + 6'(i);
                card_ack = 1'b1;
                @(negedge clk);
            end
            card_ack = 1'b0;
        end
    endtask

    task automatic fresh_hand(input logic [5:0] base);
        do_reset();
        pulse_start();
        deal(4, base);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t;
        reset = 1'b0; btn_start = 1'b0; act_check_call = 1'b0; act_bet_raise = 1'b0;
        act_fold = 1'b0; bet_amount = '0; card_ack = 1'b0; card_in = '0;
        eval_done = 1'b0; eval_winner = 1'b0; eval_tie = 1'b0;

        //               cc    br    fd    amt      s0       s1       p0       p1       call    minr    cp    ifbc
        vecs[0] = '{1'b0, 1'b0, 1'b0, 11'd0,  11'd990, 11'd980, 11'd10,  11'd20, 11'd10, 11'd20, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 11'd5,  11'd960, 11'd980, 11'd40,  11'd20, 11'd20, 11'd20, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 11'd50, 11'd960, 11'd910, 11'd40,  11'd90, 11'd50, 11'd50, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 11'd0,  11'd860, 11'd910, 11'd140, 11'd90, 11'd50, 11'd50, 1'b1, 1'b0};

        // reset state
        do_reset();
        check("rst stack0", player_stacks[0], 1000);
        check("rst stack1", player_stacks[1], 1000);
        check("rst pot0", player_pots[0], 0);
        check("rst pot_size", pot_size, 0);
        check("rst call_size", call_size, 0);
        check("rst min_raise", min_bet_or_raise, 20);
        check("rst if_BetCheck", if_BetCheck, 1);
        check("rst players", {current_player, current_dealer, winner}, 0);
        check("rst curr_state", curr_state, HS_PREFLOP);
        check("rst screens", {start_state, game_state, wait_state}, 3'b100);
        check("rst req/start", {card_req, eval_start}, 0);

        // ack without request is ignored
        card_in = 6'h3f; card_ack = 1'b1;
        @(negedge clk); @(negedge clk);
        card_ack = 1'b0;
        check("idle ack card", player_cards[0][0], 0);

        // hand A: betting table then flop and a postflop fold
        fresh_hand(6'h10);
        check("deal order [0][0]", player_cards[0][0], 6'h10);
        check("deal order [1][0]", player_cards[1][0], 6'h11);
        check("deal order [0][1]", player_cards[0][1], 6'h12);
        check("deal order [1][1]", player_cards[1][1], 6'h13);
        check("deal game_state", game_state, 1);
        for (int i = 0; i < 4; i++) begin
            act(vecs[i].cc, vecs[i].br, vecs[i].fd, vecs[i].amt);
            @(negedge clk);
            check($sformatf("v%0d stack0", i), player_stacks[0], vecs[i].s0);
            check($sformatf("v%0d stack1", i), player_stacks[1], vecs[i].s1);
            check($sformatf("v%0d pot0", i), player_pots[0], vecs[i].p0);
            check($sformatf("v%0d pot1", i), player_pots[1], vecs[i].p1);
            check($sformatf("v%0d call_size", i), call_size, vecs[i].call);
            check($sformatf("v%0d min_raise", i), min_bet_or_raise, vecs[i].minr);
            check($sformatf("v%0d cur_player", i), current_player, vecs[i].cp);
            check($sformatf("v%0d if_BetCheck", i), if_BetCheck, vecs[i].ifbc);
        end
        act(1'b1, 1'b0, 1'b0, 11'd0);
        deal(3, 6'h20);
        @(negedge clk);
        check("A flop card2", flop_card[2], 6'h22);
        check("A pot_size", pot_size, 280);
        check("A pots", {player_pots[0], player_pots[1]}, 0);
        check("A stacks", {player_stacks[0], player_stacks[1]}, {11'd860, 11'd860});
        check("A curr_state", curr_state, HS_FLOP);
        check("A first postflop", current_player, 1);
        check("A min reset", min_bet_or_raise, 20);
        act(1'b0, 1'b0, 1'b1, 11'd0);
        check("A fold stack0", player_stacks[0], 1140);
        check("A fold pot_size", pot_size, 0);
        check("A fold winner", winner, 0);
        check("A fold wait_state", wait_state, 1);

        // hand B: limp and check preflop, then flop
        fresh_hand(6'h01);
        act(1'b1, 1'b0, 1'b0, 11'd0);
        check("B call pots", {player_pots[0], player_pots[1]}, {11'd20, 11'd20});
        act(1'b1, 1'b0, 1'b0, 11'd0);
        deal(3, 6'h05);
        @(negedge clk);
        check("B pot_size", pot_size, 40);
        check("B pots", {player_pots[0], player_pots[1]}, 0);
        check("B curr_state", curr_state, HS_FLOP);
        check("B cur_player", current_player, 1);
        check("B if_BetCheck", if_BetCheck, 1);
        check("B call_size", call_size, 0);

        // hand C: fold beats check_call, then next hand with toggled dealer
        fresh_hand(6'h01);
        act(1'b1, 1'b0, 1'b1, 11'd0);
        check("C stack1", player_stacks[1], 1010);
        check("C stack0", player_stacks[0], 990);
        check("C winner", winner, 1);
        check("C wait_state", wait_state, 1);
        pulse_start();
        deal(4, 6'h08);
        @(negedge clk);
        check("C2 dealer", current_dealer, 1);
        check("C2 dealer SB", {player_stacks[1], player_pots[1]}, {11'd1000, 11'd10});
        check("C2 other BB", {player_stacks[0], player_pots[0]}, {11'd970, 11'd20});
        check("C2 first to act", current_player, 1);
        act(1'b1, 1'b1, 1'b0, 11'd0);
        @(negedge clk);
        check("C2 raise beats call", {player_stacks[1], player_pots[1]}, {11'd970, 11'd40});
        check("C2 opp call_size", call_size, 20);

        // hand D: all-in and call, run-out, tied showdown
        fresh_hand(6'h01);
        act(1'b0, 1'b1, 1'b0, 11'd2047);
        check("D allin p0", {player_stacks[0], player_pots[0]}, {11'd0, 11'd1000});
        act(1'b1, 1'b0, 1'b0, 11'd0);
        check("D call p1", {player_stacks[1], player_pots[1]}, {11'd0, 11'd1000});
        deal(3, 6'h20);
        deal(1, 6'h23);
        deal(1, 6'h24);
        t = 0;
        while (eval_start !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("D eval_start", eval_start, 1);
        check("D showdown", curr_state, HS_SHOWDOWN);
        check("D pot_size", pot_size, 2000);
        check("D river", river_card, 6'h24);
        @(negedge clk);
        check("D eval_start 1 cycle", eval_start, 0);
        eval_done = 1'b1; eval_tie = 1'b1; eval_winner = 1'b0;
        @(negedge clk);
        eval_done = 1'b0; eval_tie = 1'b0;
        @(negedge clk);
        check("D tie stacks", {player_stacks[0], player_stacks[1]}, {11'd1000, 11'd1000});
        check("D tie pot_size", pot_size, 0);
        check("D wait_state", wait_state, 1);

        // hand E: reset during DEAL
        do_reset();
        pulse_start();
        t = 0;
        while (card_req !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        card_in = 6'h2a; card_ack = 1'b1;
        @(negedge clk); @(negedge clk);
        card_ack = 1'b0;
        check("E card before reset", player_cards[0][0], 6'h2a);
        reset = 1'b1;
        @(negedge clk);
        check("E card_req dropped", card_req, 0);
        check("E screens", {start_state, game_state, wait_state}, 3'b100);
        check("E card cleared", player_cards[0][0], 0);
        check("E stacks", {player_stacks[0], player_stacks[1]}, {11'd1000, 11'd1000});
        check("E pots", {player_pots[0], player_pots[1]}, 0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
